// File: rtl/pu_shift.sv
// pu_shift: bus-attached PU holding one operand, shifting by 1 or 8 bits (logical/arithmetic, left/right)
module pu_shift #(
   parameter int DATA_WIDTH = 32,
   parameter int ATTR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signal_work,
   input  logic                  signal_direction,
   input  logic                  signal_mode,
   input  logic                  signal_step,
   input  logic                  signal_init,
   input  logic                  signal_oe,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ATTR_WIDTH-1:0] attr_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ATTR_WIDTH-1:0] attr_out
);
   logic [DATA_WIDTH-1:0] d_q, d_d, shl, shr;
   logic [ATTR_WIDTH-1:0] a_q, a_d;
   logic signed [DATA_WIDTH:0] ext;
   // extra top bit carries the fill value, so one arithmetic shift covers both right modes
   assign ext = {signal_mode & d_q[DATA_WIDTH-1], d_q};
   always_comb begin
      shl = signal_step ? d_q << 8 : d_q << 1;
      shr = signal_step ? DATA_WIDTH'(ext >>> 8) : DATA_WIDTH'(ext >>> 1);
      d_d = signal_init ? data_in : signal_work ? (signal_direction ? shl : shr) : d_q;
      a_d = signal_init ? attr_in : a_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_q <= '0;
         a_q <= '0;
      end else begin
         d_q <= d_d;
         a_q <= a_d;
      end
   end
   assign data_out = signal_oe ? d_q : '0;
   assign attr_out = signal_oe ? a_q : '0;
endmodule

// File: tb/tb_pu_shift.sv
// tb_pu_shift: scoreboard bench for pu_shift against an arithmetic reference model
module tb_pu_shift;
   logic        clk = 0, rst = 1;
   logic        signal_work = 0, signal_direction = 0, signal_mode = 0;
   logic        signal_step = 0, signal_init = 0, signal_oe = 0;
   logic [31:0] data_in = 0, data_out;
   logic [3:0]  attr_in = 0, attr_out;
   logic [31:0] m_d = 0;
   logic [3:0]  m_a = 0;
   logic [31:0] exp_d[$];
   logic [3:0]  exp_a[$];
   int          pass_cnt = 0, total_cnt = 0;

   pu_shift #(.DATA_WIDTH(32), .ATTR_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .signal_work(signal_work), .signal_direction(signal_direction),
      .signal_mode(signal_mode), .signal_step(signal_step), .signal_init(signal_init),
      .signal_oe(signal_oe), .data_in(data_in), .attr_in(attr_in),
      .data_out(data_out), .attr_out(attr_out)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [35:0] got, logic [35:0] want);
      total_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s: got %h, required %h", name, got, want);
   endtask

   // shift as multiplication / floor division of the unsigned or two's-complement value
   function automatic logic [31:0] ref_shift(logic [31:0] d, bit left, bit arith, bit step);
      longint p, v;
      p = step ? 64'sd256 : 64'sd2;
      if (left) return 32'((longint'(d) * p) % 64'sh1_0000_0000);
      if (!arith || !d[31]) return 32'(longint'(d) / p);
      v = longint'(d) - 64'sh1_0000_0000;
      return 32'((v - (p - 1)) / p);
   endfunction

   task automatic cyc(bit w, bit dir, bit md, bit st, bit in, bit oe, logic [31:0] di, logic [3:0] ai);
      logic [31:0] nd;
      logic [3:0]  na;
      signal_work = w; signal_direction = dir; signal_mode = md; signal_step = st;
      signal_init = in; signal_oe = oe; data_in = di; attr_in = ai;
      if (oe) begin exp_d.push_back(m_d); exp_a.push_back(m_a); end
      nd = in ? di : w ? ref_shift(m_d, dir, md, st) : m_d;
      na = in ? ai : m_a;
      @(posedge clk);
      #1;
      m_d = nd;
      m_a = na;
   endtask

   task automatic nop(bit oe);
      cyc(0, 0, 0, 0, 0, oe, $urandom, 4'($urandom));
   endtask

   always @(negedge clk) begin
      if (rst || !signal_oe) begin
         check("gated_out", {attr_out, data_out}, 36'd0);
      end else if (exp_d.size() == 0) begin
         total_cnt++;
         $display("FAIL scoreboard_empty: got %h, required nothing pending", data_out);
      end else begin
         check("data_out", {4'd0, data_out}, {4'd0, exp_d.pop_front()});
         check("attr_out", {attr_out, 32'd0}, {exp_a.pop_front(), 32'd0});
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      nop(0); nop(1);
      // init 0x10, left 1, three arithmetic rights
      cyc(0,0,0,0,1,0,32'h10,4'h3); cyc(1,1,1,0,0,0,0,0); nop(1);
      repeat (3) cyc(1,0,1,0,0,0,0,0);
      nop(1); nop(0); nop(0);
      cyc(0,0,0,0,1,0,32'hFFFFFFF0,0); cyc(1,0,1,0,0,0,0,0); nop(1);
      cyc(0,0,0,0,1,0,32'hFFFFFFF0,0); cyc(1,0,0,0,0,0,0,0); nop(1);
      cyc(0,0,0,0,1,0,32'h80000000,0); cyc(1,0,1,1,0,0,0,0); nop(1);
      cyc(0,0,0,0,1,0,32'h10,0);       cyc(1,1,0,1,0,0,0,0); nop(1);
      cyc(0,0,0,0,1,0,32'h12345678,0); cyc(1,0,0,1,0,0,0,0); nop(1);
      // attributes survive shifts
      cyc(0,0,0,0,1,0,32'h5,4'hA); cyc(1,1,0,0,0,1,0,0); cyc(1,0,1,1,0,0,0,0); nop(1); nop(0);
      // oe coinciding with work shows the pre-edge value
      cyc(0,0,0,0,1,0,32'h20,0); cyc(1,0,0,0,0,1,0,0); nop(1);
      // init beats work in the same cycle
      cyc(1,1,0,1,1,0,32'hCAFE0001,4'h7); nop(1);
      // asynchronous reset between edges
      signal_oe = 1; signal_work = 0; signal_init = 0;
      #2 rst = 1;
      #1 check("async_rst_now", {attr_out, data_out}, 36'd0);
      @(negedge clk);
      #1 rst = 0;
      m_d = 0; m_a = 0; signal_oe = 0;
      @(posedge clk);
      #1 nop(1);
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
             $urandom_range(0,5) == 0, $urandom_range(0,1), $urandom, 4'($urandom));
      nop(0);
      total_cnt++;
      if (exp_d.size() == 0) pass_cnt++;
      else $display("FAIL drain: got %0d pending, required 0", exp_d.size());
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
